// File: rtl/wb_sram8_bridge_pkg.sv
// Shared constants and state encoding for the Wishbone to 8-bit async SRAM bridge.
`ifndef RW
`define RW 16
`endif

package wb_sram8_bridge_pkg;

    localparam int unsigned DW    = `RW;
    localparam int unsigned BW    = 8;
    localparam int unsigned CNT_W = 4;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_ACK    = 3'd4,
        ST_XFER   = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    function automatic logic [BW-1:0] lane_byte(input logic [DW-1:0] word, input logic lane);
        return lane ? word[2*BW-1:BW] : word[BW-1:0];
    endfunction

endpackage

// File: rtl/wb_sram8_bridge_if.sv
// Wishbone slave and SRAM pin bundle for wb_sram8_bridge.
// WB_ERR_EN adds the wb_err response line.
interface wb_sram8_bridge_if #(
    parameter int unsigned AW = 16
);
    import wb_sram8_bridge_pkg::*;

    logic          wb_cyc;
    logic          wb_stb;
    logic          wb_we;
    logic [AW-1:0] wb_adr;
    logic [DW-1:0] wb_i_dat;
    logic [1:0]    wb_sel;
    logic [DW-1:0] wb_o_dat;
    logic          wb_ack;
`ifdef WB_ERR_EN
    logic          wb_err;
`endif

    logic [AW:0]   sram_adr;
    logic [BW-1:0] sram_dq_o;
    logic [BW-1:0] sram_dq_i;
    logic          sram_dq_oe;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_i_dat, wb_sel,
        input  wb_o_dat, wb_ack
`ifdef WB_ERR_EN
        , input wb_err
`endif
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_i_dat, wb_sel, sram_dq_i,
        output wb_o_dat, wb_ack, sram_adr, sram_dq_o, sram_dq_oe,
               sram_ce_n, sram_oe_n, sram_we_n
`ifdef WB_ERR_EN
        , output wb_err
`endif
    );

    modport mem (
        input  sram_adr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n,
        output sram_dq_i
    );

endinterface

// File: rtl/sram8_byte_cycle.sv
// One async SRAM byte access: SETUP (1 clk), STROBE (WAIT_CYC clks), HOLD (1 clk).
// A start seen in HOLD chains straight into the next SETUP with chip enable kept low.
module sram8_byte_cycle
    import wb_sram8_bridge_pkg::*;
#(
    parameter int unsigned AW       = 16,
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          start,
    input  logic          we,
    input  logic [AW:0]   adr,
    input  logic [BW-1:0] wdata,
    input  logic [BW-1:0] dq_i,
    output logic [AW:0]   sram_adr,
    output logic [BW-1:0] sram_dq_o,
    output logic          sram_dq_oe,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic          done_c,
    output logic          rd_vld_c,
    output logic [BW-1:0] rd_byte_c
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [AW:0]      adr_q, adr_d;
    logic [BW-1:0]    dq_o_q, dq_o_d;
    logic             dq_oe_q, dq_oe_d;
    logic             ce_n_q, ce_n_d;
    logic             oe_n_q, oe_n_d;
    logic             we_n_q, we_n_d;
    logic             accept_c;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dq_o_q  <= '0;
            dq_oe_q <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dq_o_q  <= dq_o_d;
            dq_oe_q <= dq_oe_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_SETUP;
            ST_SETUP: begin
                state_d = ST_STROBE;
                cnt_d   = CNT_LOAD;
            end
            ST_STROBE: begin
                if (cnt_q == '0) state_d = ST_HOLD;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_HOLD:   state_d = start ? ST_SETUP : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Pin values are registered from the next state so they change cleanly on the edge.
    always_comb begin
        accept_c = start && ((state_q == ST_IDLE) || (state_q == ST_HOLD));
        we_d     = we_q;
        adr_d    = adr_q;
        dq_o_d   = dq_o_q;
        if (accept_c) begin
            we_d  = we;
            adr_d = adr;
            if (we) dq_o_d = wdata;
        end
        dq_oe_d   = (state_d != ST_IDLE) && we_d;
        ce_n_d    = (state_d == ST_IDLE);
        oe_n_d    = !((state_d == ST_STROBE) && !we_d);
        we_n_d    = !((state_d == ST_STROBE) && we_d);
        done_c    = (state_q == ST_HOLD);
        rd_vld_c  = (state_q == ST_STROBE) && (cnt_q == '0) && !we_q;
        rd_byte_c = dq_i;
    end

    assign sram_adr   = adr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;

endmodule

// File: rtl/wb_sram8_bridge.sv
// Wishbone classic slave serving 16-bit words from an 8-bit async SRAM, low lane first.
// WB_ERR_EN enables wb_err for word addresses at or beyond MEM_WORDS.
module wb_sram8_bridge
    import wb_sram8_bridge_pkg::*;
#(
    parameter int unsigned AW       = 16,
    parameter int unsigned WAIT_CYC = 2
`ifdef WB_ERR_EN
    , parameter int unsigned MEM_WORDS = 65536
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst,
    wb_sram8_bridge_if.slave  bus
);

    state_e        state_q, state_d;
    logic [AW-1:0] adr_q, adr_d;
    logic          we_q, we_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          lane_q, lane_d;
    logic          pend_hi_q, pend_hi_d;
    logic          abort_q, abort_d;
    logic          wb_ack_q, wb_ack_d;
    logic [DW-1:0] wb_o_dat_q, wb_o_dat_d;
`ifdef WB_ERR_EN
    logic          wb_err_q, wb_err_d;
`endif

    logic          req_c, oob_c, abort_c, accept_c;
    logic          start_c, st_we_c, st_lane_c;
    logic [AW-1:0] st_adr_c;
    logic [DW-1:0] st_dat_c;
    logic          done_c, rd_vld_c;
    logic [BW-1:0] rd_byte_c;

    assign req_c   = bus.wb_cyc && bus.wb_stb;
    assign abort_c = abort_q || !bus.wb_cyc;
`ifdef WB_ERR_EN
    assign oob_c   = 32'(bus.wb_adr) >= MEM_WORDS;
`else
    assign oob_c   = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            adr_q      <= '0;
            we_q       <= 1'b0;
            dat_q      <= '0;
            lane_q     <= LANE_LO;
            pend_hi_q  <= 1'b0;
            abort_q    <= 1'b0;
            wb_ack_q   <= 1'b0;
            wb_o_dat_q <= '0;
`ifdef WB_ERR_EN
            wb_err_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            we_q       <= we_d;
            dat_q      <= dat_d;
            lane_q     <= lane_d;
            pend_hi_q  <= pend_hi_d;
            abort_q    <= abort_d;
            wb_ack_q   <= wb_ack_d;
            wb_o_dat_q <= wb_o_dat_d;
`ifdef WB_ERR_EN
            wb_err_q   <= wb_err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_c) begin
                    if (oob_c)                       state_d = ST_ERR;
                    else if (bus.wb_sel == 2'b00)    state_d = ST_ACK;
                    else                             state_d = ST_XFER;
                end
            end
            // An aborted word still finishes its current byte; later lanes are dropped.
            ST_XFER: begin
                if (done_c) begin
                    if (abort_c)        state_d = ST_IDLE;
                    else if (pend_hi_q) state_d = ST_XFER;
                    else                state_d = ST_ACK;
                end
            end
            ST_ACK, ST_ERR: state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        adr_d      = adr_q;
        we_d       = we_q;
        dat_d      = dat_q;
        lane_d     = lane_q;
        pend_hi_d  = pend_hi_q;
        abort_d    = abort_q;
        wb_o_dat_d = wb_o_dat_q;
        start_c    = 1'b0;
        st_we_c    = we_q;
        st_lane_c  = lane_q;
        st_adr_c   = adr_q;
        st_dat_c   = dat_q;
        accept_c   = (state_q == ST_IDLE) && req_c && !oob_c;

        if (accept_c) begin
            adr_d     = bus.wb_adr;
            we_d      = bus.wb_we;
            dat_d     = bus.wb_i_dat;
            lane_d    = bus.wb_sel[0] ? LANE_LO : LANE_HI;
            pend_hi_d = &bus.wb_sel;
            abort_d   = 1'b0;
            if (!bus.wb_we) wb_o_dat_d = '0;
            start_c   = (bus.wb_sel != 2'b00);
            st_we_c   = bus.wb_we;
            st_lane_c = lane_d;
            st_adr_c  = bus.wb_adr;
            st_dat_c  = bus.wb_i_dat;
        end

        if (state_q == ST_XFER) begin
            if (!bus.wb_cyc) abort_d = 1'b1;
            if (rd_vld_c) begin
                if (lane_q == LANE_HI) wb_o_dat_d[2*BW-1:BW] = rd_byte_c;
                else                   wb_o_dat_d[BW-1:0]    = rd_byte_c;
            end
            if (done_c && (state_d == ST_XFER)) begin
                start_c   = 1'b1;
                lane_d    = LANE_HI;
                pend_hi_d = 1'b0;
                st_lane_c = LANE_HI;
            end
        end

        wb_ack_d = (state_d == ST_ACK);
`ifdef WB_ERR_EN
        wb_err_d = (state_d == ST_ERR);
`endif
    end

    sram8_byte_cycle #(
        .AW       (AW),
        .WAIT_CYC (WAIT_CYC)
    ) u_byte_cycle (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .start      (start_c),
        .we         (st_we_c),
        .adr        ({st_adr_c, st_lane_c}),
        .wdata      (lane_byte(st_dat_c, st_lane_c)),
        .dq_i       (bus.sram_dq_i),
        .sram_adr   (bus.sram_adr),
        .sram_dq_o  (bus.sram_dq_o),
        .sram_dq_oe (bus.sram_dq_oe),
        .sram_ce_n  (bus.sram_ce_n),
        .sram_oe_n  (bus.sram_oe_n),
        .sram_we_n  (bus.sram_we_n),
        .done_c     (done_c),
        .rd_vld_c   (rd_vld_c),
        .rd_byte_c  (rd_byte_c)
    );

    assign bus.wb_ack   = wb_ack_q;
    assign bus.wb_o_dat = wb_o_dat_q;
`ifdef WB_ERR_EN
    assign bus.wb_err   = wb_err_q;
`endif

endmodule

// File: tb/tb_wb_sram8_bridge.sv
// Directed self-checking bench for wb_sram8_bridge with a byte-wide SRAM model.
module tb_wb_sram8_bridge;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    wb_sram8_bridge_if #(.AW(16)) bus();

    wb_sram8_bridge #(
        .AW       (16),
        .WAIT_CYC (2)
`ifdef WB_ERR_EN
        , .MEM_WORDS(32'h4000)
`endif
    ) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    logic [7:0]  mem [0:131071];
    logic        pre_we  = 1'b0;
    logic [16:0] pre_adr = '0;
    logic [7:0]  pre_dat = '0;

    // SRAM model: writes while ce/we low, reads return 5A outside the oe window.
    always @(posedge clk) begin
        if (pre_we) mem[pre_adr] <= pre_dat;
        else if (!bus.sram_ce_n && !bus.sram_we_n && bus.sram_dq_oe) mem[bus.sram_adr] <= bus.sram_dq_o;
    end
    assign bus.sram_dq_i = (!bus.sram_ce_n && !bus.sram_oe_n) ? mem[bus.sram_adr] : 8'h5A;

    task automatic preload(input logic [16:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_adr = a; pre_dat = d; pre_we = 1'b1;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic bus_idle();
        bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
        bus.wb_adr = '0; bus.wb_i_dat = '0; bus.wb_sel = 2'b00;
    endtask

    task automatic test_reset();
        bus_idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.sram_ce_n !== 1'b1) begin failures++; $display("FAIL reset_ce_n got=%b want=1", bus.sram_ce_n); end
        checks++; if (bus.sram_oe_n !== 1'b1) begin failures++; $display("FAIL reset_oe_n got=%b want=1", bus.sram_oe_n); end
        checks++; if (bus.sram_we_n !== 1'b1) begin failures++; $display("FAIL reset_we_n got=%b want=1", bus.sram_we_n); end
        checks++; if (bus.sram_dq_oe !== 1'b0) begin failures++; $display("FAIL reset_dq_oe got=%b want=0", bus.sram_dq_oe); end
        checks++; if (bus.wb_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b want=0", bus.wb_ack); end
        checks++; if (bus.wb_o_dat !== 16'h0000) begin failures++; $display("FAIL reset_o_dat got=%h want=0000", bus.wb_o_dat); end
        checks++; if (bus.sram_adr !== 17'h0) begin failures++; $display("FAIL reset_sram_adr got=%h want=0", bus.sram_adr); end
        checks++; if (bus.sram_dq_o !== 8'h00) begin failures++; $display("FAIL reset_dq_o got=%h want=00", bus.sram_dq_o); end
        rst = 1'b0;
    endtask

    task automatic test_write();
        int ack_cyc = -1, acks = 0, we_lo = 0, we_hi = 0, we_bad = 0;
        logic [16:0] adr1; logic ce1, we1, oe1;
        preload(17'h00246, 8'h00);
        preload(17'h00247, 8'h00);
        @(negedge clk);
        bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b1;
        bus.wb_adr = 16'h0123; bus.wb_i_dat = 16'hBEEF; bus.wb_sel = 2'b11;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (!bus.sram_we_n) begin
                if (bus.sram_adr == 17'h00246) we_lo++;
                else if (bus.sram_adr == 17'h00247) we_hi++;
                else we_bad++;
            end
            if (k == 1) begin adr1 = bus.sram_adr; ce1 = bus.sram_ce_n; we1 = bus.sram_we_n; oe1 = bus.sram_dq_oe; end
            if (bus.wb_ack) begin
                acks++;
                if (ack_cyc < 0) ack_cyc = k;
                bus_idle();
            end
        end
        checks++; if (ack_cyc != 9) begin failures++; $display("FAIL wr_ack_cycle got=%0d want=9", ack_cyc); end
        checks++; if (acks != 1) begin failures++; $display("FAIL wr_ack_count got=%0d want=1", acks); end
        checks++; if (we_lo != 2) begin failures++; $display("FAIL wr_we_lo_cycles got=%0d want=2", we_lo); end
        checks++; if (we_hi != 2) begin failures++; $display("FAIL wr_we_hi_cycles got=%0d want=2", we_hi); end
        checks++; if (we_bad != 0) begin failures++; $display("FAIL wr_we_bad_adr got=%0d want=0", we_bad); end
        checks++; if (adr1 !== 17'h00246 || ce1 !== 1'b0 || we1 !== 1'b1 || oe1 !== 1'b1)
            begin failures++; $display("FAIL wr_setup adr=%h ce_n=%b we_n=%b dq_oe=%b want 00246/0/1/1", adr1, ce1, we1, oe1); end
        checks++; if (mem[17'h00246] !== 8'hEF) begin failures++; $display("FAIL wr_mem_lo got=%h want=EF", mem[17'h00246]); end
        checks++; if (mem[17'h00247] !== 8'hBE) begin failures++; $display("FAIL wr_mem_hi got=%h want=BE", mem[17'h00247]); end
    endtask

    task automatic test_read();
        int ack_cyc = -1, ce_lo = 0, oe_lo = 0, oe_bad = 0;
        logic [15:0] rdat = '0;
        @(negedge clk);
        bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b0;
        bus.wb_adr = 16'h0123; bus.wb_sel = 2'b10;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (!bus.sram_ce_n) ce_lo++;
            if (!bus.sram_oe_n) begin oe_lo++; if (bus.sram_adr != 17'h00247) oe_bad++; end
            if (bus.wb_ack && ack_cyc < 0) begin ack_cyc = k; rdat = bus.wb_o_dat; bus_idle(); end
        end
        checks++; if (ack_cyc != 5) begin failures++; $display("FAIL rd_ack_cycle got=%0d want=5", ack_cyc); end
        checks++; if (rdat !== 16'hBE00) begin failures++; $display("FAIL rd_data got=%h want=BE00", rdat); end
        checks++; if (ce_lo != 4) begin failures++; $display("FAIL rd_ce_cycles got=%0d want=4", ce_lo); end
        checks++; if (oe_lo != 2 || oe_bad != 0) begin failures++; $display("FAIL rd_oe got=%0d/%0d want=2/0", oe_lo, oe_bad); end
    endtask

    task automatic test_empty_sel();
        int ack_cyc = -1, ce_lo = 0;
        @(negedge clk);
        bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b1;
        bus.wb_adr = 16'h0123; bus.wb_i_dat = 16'hFFFF; bus.wb_sel = 2'b00;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (!bus.sram_ce_n) ce_lo++;
            if (bus.wb_ack && ack_cyc < 0) begin ack_cyc = k; bus_idle(); end
        end
        checks++; if (ack_cyc != 1) begin failures++; $display("FAIL sel0_ack_cycle got=%0d want=1", ack_cyc); end
        checks++; if (ce_lo != 0) begin failures++; $display("FAIL sel0_ce_cycles got=%0d want=0", ce_lo); end
        checks++; if (bus.wb_o_dat !== 16'hBE00) begin failures++; $display("FAIL sel0_o_dat_held got=%h want=BE00", bus.wb_o_dat); end
        checks++; if (mem[17'h00246] !== 8'hEF) begin failures++; $display("FAIL sel0_mem got=%h want=EF", mem[17'h00246]); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_w [4];
        int beat = 0, last_ack = -1, gap_bad = 0, dbl = 0;
        logic prev_ack = 1'b0;
        exp_w[0] = 16'h2211; exp_w[1] = 16'h4433; exp_w[2] = 16'h6655; exp_w[3] = 16'h8877;
        for (int i = 0; i < 8; i++) preload(17'h00080 + 17'(i), 8'((i + 1) * 8'h11));
        @(negedge clk);
        bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b0;
        bus.wb_adr = 16'h0040; bus.wb_sel = 2'b11;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (bus.wb_ack) begin
                if (prev_ack) dbl++;
                if (last_ack >= 0 && k - last_ack != 10) gap_bad++;
                last_ack = k;
                if (beat < 4) begin
                    checks++;
                    if (bus.wb_o_dat !== exp_w[beat]) begin
                        failures++; $display("FAIL fill_beat%0d got=%h want=%h", beat, bus.wb_o_dat, exp_w[beat]);
                    end
                end
                beat++;
                if (beat >= 4) bus_idle();
                else bus.wb_adr = 16'h0040 + 16'(beat);
            end
            prev_ack = bus.wb_ack;
        end
        checks++; if (beat != 4) begin failures++; $display("FAIL fill_ack_count got=%0d want=4", beat); end
        checks++; if (dbl != 0) begin failures++; $display("FAIL fill_double_ack got=%0d want=0", dbl); end
        checks++; if (gap_bad != 0) begin failures++; $display("FAIL fill_ack_spacing got=%0d want=0", gap_bad); end
    endtask

    task automatic test_abort();
        int we_lo = 0, ce_lo = 0, acks = 0;
        logic ce4 = 1'b1, ce5 = 1'b0;
        preload(17'h000A0, 8'h00);
        preload(17'h000A1, 8'h00);
        @(negedge clk);
        bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b1;
        bus.wb_adr = 16'h0050; bus.wb_i_dat = 16'h1234; bus.wb_sel = 2'b11;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (!bus.sram_we_n) we_lo++;
            if (!bus.sram_ce_n) ce_lo++;
            if (bus.wb_ack) acks++;
            if (k == 4) ce4 = bus.sram_ce_n;
            if (k == 5) ce5 = bus.sram_ce_n;
            if (k == 2) bus_idle();
        end
        checks++; if (we_lo != 2) begin failures++; $display("FAIL abort_we_cycles got=%0d want=2", we_lo); end
        checks++; if (ce_lo != 4) begin failures++; $display("FAIL abort_ce_cycles got=%0d want=4", ce_lo); end
        checks++; if (acks != 0) begin failures++; $display("FAIL abort_ack_count got=%0d want=0", acks); end
        checks++; if (ce4 !== 1'b0 || ce5 !== 1'b1) begin failures++; $display("FAIL abort_hold_then_idle ce4=%b ce5=%b want 0/1", ce4, ce5); end
        checks++; if (mem[17'h000A0] !== 8'h34) begin failures++; $display("FAIL abort_mem_lo got=%h want=34", mem[17'h000A0]); end
        checks++; if (mem[17'h000A1] !== 8'h00) begin failures++; $display("FAIL abort_mem_hi got=%h want=00", mem[17'h000A1]); end
    endtask

`ifdef WB_ERR_EN
    task automatic test_err();
        int err_cyc = -1, errs = 0, acks = 0, ce_lo = 0;
        @(negedge clk);
        bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b0;
        bus.wb_adr = 16'h4000; bus.wb_sel = 2'b11;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (!bus.sram_ce_n) ce_lo++;
            if (bus.wb_ack) acks++;
            if (bus.wb_err) begin errs++; if (err_cyc < 0) err_cyc = k; bus_idle(); end
        end
        checks++; if (err_cyc != 1 || errs != 1) begin failures++; $display("FAIL err_pulse cyc=%0d n=%0d want 1/1", err_cyc, errs); end
        checks++; if (acks != 0) begin failures++; $display("FAIL err_ack got=%0d want=0", acks); end
        checks++; if (ce_lo != 0) begin failures++; $display("FAIL err_ce_cycles got=%0d want=0", ce_lo); end
        checks++; if (bus.wb_o_dat !== 16'h8877) begin failures++; $display("FAIL err_o_dat got=%h want=8877", bus.wb_o_dat); end
    endtask
`endif

    task automatic test_reset_midop();
        @(negedge clk);
        bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b1;
        bus.wb_adr = 16'h0060; bus.wb_i_dat = 16'hAAAA; bus.wb_sel = 2'b01;
        repeat (2) @(negedge clk);
        checks++; if (bus.sram_we_n !== 1'b0) begin failures++; $display("FAIL rst_mid_pre_we_n got=%b want=0", bus.sram_we_n); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.sram_we_n !== 1'b1 || bus.sram_ce_n !== 1'b1 || bus.sram_oe_n !== 1'b1)
            begin failures++; $display("FAIL rst_mid_ctl we_n=%b ce_n=%b oe_n=%b want 1/1/1", bus.sram_we_n, bus.sram_ce_n, bus.sram_oe_n); end
        checks++; if (bus.sram_dq_oe !== 1'b0 || bus.wb_ack !== 1'b0)
            begin failures++; $display("FAIL rst_mid_oe_ack dq_oe=%b ack=%b want 0/0", bus.sram_dq_oe, bus.wb_ack); end
        bus_idle();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_empty_sel();
        test_back_to_back();
        test_abort();
`ifdef WB_ERR_EN
        test_err();
`endif
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
